counter_updown_mod: RTL and testbench

Parametrised successor of the team's 4-bit enable counter. Adds the following over it:
- generic width and modulus
- up/down direction
- synchronous clear and parallel load
- wrap or saturate mode
- registered terminal-count pulse and sticky overflow flag

It is used as the general-purpose event/timer counter in datapath and control blocks. With WIDTH=4 and MODULO=16 it is a drop-in superset of the old counter (count=cnt, tc=cout).

---
 rtl/counter_pkg.sv | 28 ++
 rtl/counter_next_calc.sv | 49 ++++
 rtl/counter_updown_mod.sv | 99 +++++++++
 tb/tb_counter_updown_mod.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and parameter-legality helper for the up/down event counter.
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } count_dir_e;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } bound_mode_e;

   localparam int MIN_WIDTH  = 1;
   localparam int MAX_WIDTH  = 32;
   localparam longint MIN_MODULO = 2;

   // 64-bit arithmetic so MODULO may equal 2**32 when WIDTH is 32.
   function automatic bit modulo_legal(input int width, input longint modulo);
      longint span;
      if (width < MIN_WIDTH || width > MAX_WIDTH) begin
         return 1'b0;
      end
      span = longint'(1) << width;
      return (modulo >= MIN_MODULO) && (modulo <= span);
   endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational step of the counter: next value and bound detection for one enabled edge.
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] next_cnt,
   output logic             hit_bound
);

   count_dir_e  dir;
   bound_mode_e mode;

   assign dir  = count_dir_e'(up_dn);
   assign mode = bound_mode_e'(sat_mode);

   // Bounds are checked before stepping so a short modulus never relies on natural rollover.
   always_comb begin
      next_cnt  = cnt;
      hit_bound = 1'b0;
      if (en) begin
         if (dir == DIR_UP) begin
            if (cnt == MAX_VAL) begin
               hit_bound = 1'b1;
               if (mode == MODE_WRAP) begin
                  next_cnt = '0;
               end
            end else begin
               next_cnt = cnt + WIDTH'(1);
            end
         end else begin
            if (cnt == '0) begin
               hit_bound = 1'b1;
               if (mode == MODE_WRAP) begin
                  next_cnt = MAX_VAL;
               end
            end else begin
               next_cnt = cnt - WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/counter_updown_mod.sv
// General-purpose up/down counter with wrap/saturate, load, clear, terminal-count pulse
// and sticky overflow; WIDTH=4/MODULO=16 behaves as the legacy 4-bit enable counter.
module counter_updown_mod
   import counter_pkg::*;
#(
   parameter int     WIDTH  = 4,
   parameter longint MODULO = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             ovf,
   output logic             load_err,
   output logic             at_max,
   output logic             at_min
);

   if (!modulo_legal(WIDTH, MODULO)) begin : g_param_err
      $fatal(1, "counter_updown_mod: illegal WIDTH/MODULO combination");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             load_err_q, load_err_d;
   logic [WIDTH-1:0] step_cnt;
   logic             step_hit;
   logic             load_ok;

   counter_next_calc #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
   ) u_next (
      .cnt       (cnt_q),
      .en        (en),
      .up_dn     (up_dn),
      .sat_mode  (sat_mode),
      .next_cnt  (step_cnt),
      .hit_bound (step_hit)
   );

   assign load_ok = ({1'b0, load_val} < MOD_EXT);

   // Priority clr > load > en; pulses fall back to 0 unless an action raises them.
   always_comb begin
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      tc_d       = 1'b0;
      load_err_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (load) begin
         if (load_ok) begin
            cnt_d = load_val;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (en) begin
         cnt_d = step_cnt;
         if (step_hit) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         tc_q       <= 1'b0;
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tc_q       <= tc_d;
         ovf_q      <= ovf_d;
         load_err_q <= load_err_d;
      end
   end

   assign cnt      = cnt_q;
   assign tc       = tc_q;
   assign ovf      = ovf_q;
   assign load_err = load_err_q;
   assign at_max   = (cnt_q == MAX_VAL);
   assign at_min   = (cnt_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: a MODULO=10 instance for most checks and a default MODULO=16 instance
// for the legacy-compatible sequence; both share the same stimulus.
module tb_counter_updown_mod;

   logic       clk = 1'b0;
   logic       rst_n, clr, load, en, up_dn, sat_mode;
   logic [3:0] load_val;

   logic [3:0] cnt10, cnt16;
   logic       tc10, ovf10, lerr10, amax10, amin10;
   logic       tc16, ovf16, lerr16, amax16, amin16;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   counter_updown_mod #(.WIDTH(4), .MODULO(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
      .cnt(cnt10), .tc(tc10), .ovf(ovf10), .load_err(lerr10),
      .at_max(amax10), .at_min(amin10)
   );

   counter_updown_mod dut16 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
      .cnt(cnt16), .tc(tc16), .ovf(ovf16), .load_err(lerr16),
      .at_max(amax16), .at_min(amin16)
   );

   // Invariants on the MODULO=10 instance.
   a_range: assert property (@(posedge clk) disable iff (!rst_n) cnt10 < 4'd10)
      else begin mismatched++; $error("FAIL inv_range observed=%0d expected=<10", cnt10); end
   a_hold: assert property (@(posedge clk) (rst_n && !clr && !load && !en) |=> $stable(cnt10))
      else begin mismatched++; $error("FAIL inv_hold observed=%0d expected=unchanged", cnt10); end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; load = 1'b1; load_val = 4'd5;
      en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;

      // 1. reset overrides load/en
      tick(); tick();
      chk("rst_cnt", 32'(cnt10), 0);
      chk("rst_tc", 32'(tc10), 0);
      chk("rst_ovf", 32'(ovf10), 0);
      chk("rst_lerr", 32'(lerr10), 0);
      chk("rst_at_min", 32'(amin10), 1);
      chk("rst_cnt16", 32'(cnt16), 0);
      rst_n = 1'b1; load = 1'b0; en = 1'b0;
      tick(); tick();
      chk("idle_cnt", 32'(cnt10), 0);

      // 2. wrap up through MODULO=10
      en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         $display("up step %0d cnt=%0d tc=%0d ovf=%0d", i, cnt10, tc10, ovf10);
         chk("up_cnt", 32'(cnt10), 32'(i % 10));
         chk("up_tc", 32'(tc10), (i == 10) ? 1 : 0);
         chk("up_ovf", 32'(ovf10), (i == 10) ? 1 : 0);
         if (i == 9) chk("up_at_max", 32'(amax10), 1);
      end
      tick();
      chk("post_wrap_cnt", 32'(cnt10), 1);
      chk("post_wrap_tc", 32'(tc10), 0);
      chk("post_wrap_ovf", 32'(ovf10), 1);

      // 3. down wrap, saturate down, saturate up
      up_dn = 1'b0;
      tick();
      chk("dn_cnt0", 32'(cnt10), 0);
      tick();
      chk("dn_wrap_cnt", 32'(cnt10), 9);
      chk("dn_wrap_tc", 32'(tc10), 1);
      sat_mode = 1'b1; load = 1'b1; load_val = 4'd1;
      tick();
      chk("sat_ld1_cnt", 32'(cnt10), 1);
      chk("sat_ld1_tc", 32'(tc10), 0);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("sat down %0d cnt=%0d tc=%0d", i, cnt10, tc10);
         chk("satdn_cnt", 32'(cnt10), 0);
         chk("satdn_tc", 32'(tc10), (i == 0) ? 0 : 1);
      end
      load = 1'b1; load_val = 4'd8;
      tick();
      chk("sat_ld8_cnt", 32'(cnt10), 8);
      load = 1'b0; up_dn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("sat up %0d cnt=%0d tc=%0d", i, cnt10, tc10);
         chk("satup_cnt", 32'(cnt10), 9);
         chk("satup_tc", 32'(tc10), (i == 0) ? 0 : 1);
      end

      // 4. load legal, illegal, and over enable
      sat_mode = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd7;
      tick();
      chk("ld7_cnt", 32'(cnt10), 7);
      chk("ld7_lerr", 32'(lerr10), 0);
      load_val = 4'd12;
      tick();
      chk("ld12_cnt", 32'(cnt10), 7);
      chk("ld12_lerr", 32'(lerr10), 1);
      chk("ld12_cnt16", 32'(cnt16), 12);
      load = 1'b0;
      tick();
      chk("lerr_pulse_end", 32'(lerr10), 0);
      chk("ld_hold_cnt", 32'(cnt10), 7);
      load = 1'b1; en = 1'b1; load_val = 4'd3;
      tick();
      chk("ld_en_cnt", 32'(cnt10), 3);
      chk("ld_keeps_ovf", 32'(ovf10), 1);

      // 5. clear beats load/en; reset mid-count
      clr = 1'b1;
      tick();
      chk("clr_cnt", 32'(cnt10), 0);
      chk("clr_ovf", 32'(ovf10), 0);
      chk("clr_tc", 32'(tc10), 0);
      clr = 1'b0; load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_rst_cnt", 32'(cnt10), 5);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_cnt", 32'(cnt10), 0);
      rst_n = 1'b1;

      // 6. legacy sequence on the MODULO=16 instance
      for (int i = 1; i <= 17; i++) begin
         tick();
         if (i >= 15) begin
            $display("legacy step %0d cnt=%0d tc=%0d", i, cnt16, tc16);
            chk("leg_cnt", 32'(cnt16), 32'(i % 16));
            chk("leg_tc", 32'(tc16), (i == 16) ? 1 : 0);
         end
      end
      chk("leg_ovf", 32'(ovf16), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
